// File: rtl/bf8_irq_pkg.sv
// bf8_irq_pkg: interrupt IDs, dispatch states and vector table defaults shared by the IRC path.
package bf8_irq_pkg;
    localparam int INT_ID_W = 4;
    localparam logic [INT_ID_W-1:0] INT_ID_RSTB = 4'b1000;
    localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_BND,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_FLG,
        FETCH_LO,
        FETCH_HI,
        LOAD,
        ACK_WAIT
    } dispatch_state_e;

    function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [INT_ID_W-1:0] id);
        return base + {11'b0, id, 1'b0};
    endfunction
endpackage

// File: rtl/bf8_mem_port.sv
// bf8_mem_port: registered request/ready memory master, started by a write or read strobe.
module bf8_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_stb,
    input  logic        rd_stb,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rdy,
    output logic        req,
    output logic        we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        done
);
    assign done = req & rdy;

    // A strobe in the completion cycle wins, giving back-to-back transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req       <= 1'b0;
            we        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (wr_stb || rd_stb) begin
            req       <= 1'b1;
            we        <= wr_stb;
            mem_addr  <= addr;
            mem_wdata <= wdata;
        end else if (done) begin
            req <= 1'b0;
            we  <= 1'b0;
        end
    end
endmodule

// File: rtl/int_dispatch.sv
// int_dispatch: takes a pending IRC interrupt, stacks PC/FLAGS, fetches the vector,
// loads the core PC and acknowledges the IRC.
module int_dispatch
    import bf8_irq_pkg::*;
#(
    parameter logic [15:0]         VEC_BASE = VEC_BASE_DEF,
    parameter logic [INT_ID_W-1:0] RSTB_ID  = INT_ID_RSTB
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [INT_ID_W-1:0] NEXT_ID,
    input  logic                NEXT_ON,
    output logic                ACK,
    input  logic                IE,
    input  logic                INSTR_END,
    input  logic                RETI,
    output logic                BUSY,
    output logic                IN_SVC,
    output logic [INT_ID_W-1:0] ACTIVE_ID,
    input  logic [15:0]         PC_IN,
    input  logic [7:0]          FLAGS_IN,
    input  logic [15:0]         SP_IN,
    output logic                SP_DEC,
    output logic [15:0]         PC_OUT,
    output logic                PC_LOAD,
    output logic                MEM_REQ,
    output logic                MEM_WE,
    output logic [15:0]         MEM_ADDR,
    output logic [7:0]          MEM_WDATA,
    input  logic [7:0]          MEM_RDATA,
    input  logic                MEM_RDY
);
    dispatch_state_e state;
    logic [15:0] pc_q;
    logic [7:0]  flags_q;
    logic [15:0] sp_q;
    logic        wr_stb;
    logic        rd_stb;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        done;
    logic        dispatch;
    logic        rstb_now;

    assign dispatch = NEXT_ON && (NEXT_ID == RSTB_ID || (IE && !IN_SVC));
    assign rstb_now = dispatch && NEXT_ID == RSTB_ID;

    // Each memory state launches the next transfer in its completion cycle.
    always_comb begin
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        addr   = '0;
        wdata  = '0;
        case (state)
            IDLE: begin
                rd_stb = rstb_now;
                addr   = vec_addr(VEC_BASE, NEXT_ID);
            end
            WAIT_BND: begin
                wr_stb = INSTR_END;
                addr   = SP_IN;
                wdata  = PC_IN[15:8];
            end
            PUSH_PCH: begin
                wr_stb = done;
                addr   = sp_q - 16'd1;
                wdata  = pc_q[7:0];
            end
            PUSH_PCL: begin
                wr_stb = done;
                addr   = sp_q - 16'd1;
                wdata  = flags_q;
            end
            PUSH_FLG: begin
                rd_stb = done;
                addr   = vec_addr(VEC_BASE, ACTIVE_ID);
            end
            FETCH_LO: begin
                rd_stb = done;
                addr   = vec_addr(VEC_BASE, ACTIVE_ID) + 16'd1;
            end
            default: ;
        endcase
    end

    bf8_mem_port u_mem (
        .clk      (CLK),
        .rst      (RST),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .addr     (addr),
        .wdata    (wdata),
        .rdy      (MEM_RDY),
        .req      (MEM_REQ),
        .we       (MEM_WE),
        .mem_addr (MEM_ADDR),
        .mem_wdata(MEM_WDATA),
        .done     (done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ACK       <= 1'b0;
            BUSY      <= 1'b0;
            IN_SVC    <= 1'b0;
            ACTIVE_ID <= '0;
            SP_DEC    <= 1'b0;
            PC_OUT    <= '0;
            PC_LOAD   <= 1'b0;
            pc_q      <= '0;
            flags_q   <= '0;
            sp_q      <= '0;
        end else begin
            ACK     <= 1'b0;
            SP_DEC  <= 1'b0;
            PC_LOAD <= 1'b0;
            if (RETI) IN_SVC <= 1'b0;
            case (state)
                IDLE: if (dispatch) begin
                    ACTIVE_ID <= NEXT_ID;
                    // Reset-boot skips the boundary wait and the stack entirely.
                    BUSY      <= rstb_now;
                    state     <= rstb_now ? FETCH_LO : WAIT_BND;
                end
                WAIT_BND: if (INSTR_END) begin
                    pc_q    <= PC_IN;
                    flags_q <= FLAGS_IN;
                    sp_q    <= SP_IN;
                    BUSY    <= 1'b1;
                    state   <= PUSH_PCH;
                end
                PUSH_PCH, PUSH_PCL, PUSH_FLG: if (done) begin
                    SP_DEC <= 1'b1;
                    sp_q   <= sp_q - 16'd1;
                    state  <= state == PUSH_PCH ? PUSH_PCL : state == PUSH_PCL ? PUSH_FLG : FETCH_LO;
                end
                FETCH_LO: if (done) begin
                    PC_OUT[7:0] <= MEM_RDATA;
                    state       <= FETCH_HI;
                end
                FETCH_HI: if (done) begin
                    PC_OUT[15:8] <= MEM_RDATA;
                    PC_LOAD      <= 1'b1;
                    IN_SVC       <= ACTIVE_ID != RSTB_ID;
                    state        <= LOAD;
                end
                LOAD: begin
                    ACK   <= 1'b1;
                    state <= ACK_WAIT;
                end
                ACK_WAIT: if (!NEXT_ON) begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/int_dispatch.md
Name: int_dispatch

Overview:
Downstream consumer of the interrupt controller's NEXT_ID/NEXT_ON/ACK interface, sitting between the IRC and the BrainForge8 core sequencer. On a pending interrupt it waits for an instruction boundary and stalls the core. It pushes PC and FLAGS to the stack and fetches a 16-bit vector from the vector table. It then loads PC and acknowledges the IRC. It also enforces the global interrupt enable and blocks nesting until RETI.

Parameters:
VEC_BASE  16'hFFE0  vector table base; entry n at VEC_BASE+2n (low byte), VEC_BASE+2n+1 (high byte)
RSTB_ID   4'b1000   interrupt ID treated as reset-boot: non-maskable, no stack pushes

Ports:
CLK        in   1   system clock
RST        in   1   asynchronous reset, active-high
NEXT_ID    in   4   pending interrupt ID from IRC
NEXT_ON    in   1   pending interrupt valid from IRC
ACK        out  1   acknowledge to IRC, 1-cycle pulse
IE         in   1   global interrupt enable from core flags
INSTR_END  in   1   core is at an instruction boundary this cycle
RETI       in   1   1-cycle pulse, core executed return-from-interrupt
BUSY       out  1   core stall while dispatching
IN_SVC     out  1   an interrupt handler is in service
ACTIVE_ID  out  4   ID latched at dispatch start
PC_IN      in   16  current core PC
FLAGS_IN   in   8   current core flags
SP_IN      in   16  current stack pointer
SP_DEC     out  1   1-cycle pulse per completed push (core decrements SP)
PC_OUT     out  16  vector to load
PC_LOAD    out  1   1-cycle pulse, core loads PC_OUT
MEM_REQ    out  1   memory request
MEM_WE     out  1   1=write, 0=read
MEM_ADDR   out  16  memory address
MEM_WDATA  out  8   write data
MEM_RDATA  in   8   read data, valid when MEM_RDY=1
MEM_RDY    in   1   transaction completes in the cycle MEM_RDY=1 with MEM_REQ=1

Behaviour:
- Reset (RST=1, async): state IDLE. All outputs 0: ACK, BUSY, IN_SVC, ACTIVE_ID, SP_DEC, PC_OUT, PC_LOAD, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA. An in-flight memory request is abandoned.
- States: IDLE, WAIT_BND, PUSH_PCH, PUSH_PCL, PUSH_FLG, FETCH_LO, FETCH_HI, LOAD, ACK_WAIT.
- IDLE:
  - Dispatch when NEXT_ON=1 and either NEXT_ID==RSTB_ID, or (IE=1 and IN_SVC=0).
  - Otherwise remain in IDLE. The pending request is held by the IRC.
  - On dispatch, latch ACTIVE_ID=NEXT_ID, and go to WAIT_BND.
- WAIT_BND:
  - On INSTR_END=1, latch PC_IN, FLAGS_IN and SP_IN into a local SP copy, and assert BUSY from the next cycle.
  - Next state is FETCH_LO if ACTIVE_ID==RSTB_ID, else PUSH_PCH.
  - RSTB_ID does not wait for INSTR_END; it proceeds the cycle after dispatch.
- Pushes: each is a write at the local SP.
  - PUSH_PCH writes PC[15:8], PUSH_PCL writes PC[7:0], PUSH_FLG writes FLAGS.
  - On MEM_RDY: SP_DEC pulses, the local SP decrements by 1 (mod 2^16, 16'h0000 wraps to 16'hFFFF), and the state advances.
- FETCH_LO / FETCH_HI:
  - Reads from VEC_BASE+{ACTIVE_ID,1'b0} and that address +1 (16-bit wrap).
  - On MEM_RDY, capture MEM_RDATA into PC_OUT[7:0] / PC_OUT[15:8].
- Memory handshake:
  - MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA are registered and stay stable until MEM_RDY.
  - Back-to-back requests are allowed: the next state drives the new request the cycle after completion.
  - With MEM_RDY held at 1, each transaction takes 1 cycle.
- LOAD: PC_LOAD pulses for 1 cycle. IN_SVC is set, except for RSTB_ID, which clears IN_SVC.
- ACK_WAIT:
  - Entered with a 1-cycle ACK pulse.
  - Remain until NEXT_ON==0, then deassert BUSY and return to IDLE.
  - The same pending request is never dispatched twice.
- Latency with MEM_RDY tied to 1:
  - Normal interrupt, from INSTR_END to PC_LOAD: 6 cycles.
  - RSTB_ID, from dispatch to PC_LOAD: 3 cycles.
- RETI:
  - Clears IN_SVC in any state.
  - RETI in the same cycle as the LOAD set: the set wins.
- BUSY is 1 from the cycle after boundary capture through ACK_WAIT exit.
- Changes on NEXT_ID after dispatch are ignored; ACTIVE_ID is used.
- Reset mid-dispatch: immediate IDLE, no ACK, no PC_LOAD. SP_DEC pulses already issued are not undone.

Decomposition:
- Shared package bf8_irq_pkg holds:
  - the INT_ID_* constants, shared with the IRC;
  - the dispatch state enum;
  - the VEC_BASE default.
- One sub-module, bf8_mem_port, is natural: registered request/ready master with a write and read strobe. It is reused by the DMA engine.

Test Plan:
- NEXT_ID=4'h2, NEXT_ON=1, IE=1, PC_IN=16'h1234, FLAGS_IN=8'hA5, SP_IN=16'h01FF, MEM_RDY=1, INSTR_END pulse.
  - Required: writes 12@01FF, 34@01FE, A5@01FD, then reads at FFE4 and FFE5.
  - Read data 16'h4000 gives PC_OUT=16'h4000 and PC_LOAD 6 cycles after INSTR_END.
  - Then ACK pulse, IN_SVC=1 and 3 SP_DEC pulses.
- NEXT_ID=4'h8 with IE=0 and IN_SVC=1 -> no writes, reads at FFF0 and FFF1, PC_LOAD 3 cycles after NEXT_ON, IN_SVC=0.
- IE=0 with NEXT_ID=4'h0 pending for 20 cycles -> no MEM_REQ, BUSY=0. Raising IE then dispatches normally.
- MEM_RDY low for 4 cycles during PUSH_PCL -> MEM_ADDR=01FE and MEM_WDATA=34 stable throughout, a single SP_DEC pulse, and the sequence completes correctly.
- SP_IN=16'h0001 -> push addresses 0001, 0000, FFFF.
- RST asserted during FETCH_HI -> all outputs 0 the same cycle, no ACK. After release, the still-pending NEXT_ON re-dispatches from scratch.
